// File: rtl/nixie_pkg.sv
// Shared constants and types for the nixie/7-seg scan controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package nixie_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Active-high {g,f,e,d,c,b,a} patterns; entry i is hex digit i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/nixie_seg_decode.sv
// Hex nibble to active-low 7-segment pattern.
// Latency: combinational.
// Backpressure: none.
// Ports: hex (4-bit value in), seg_n (active-low {g,f,e,d,c,b,a} out).
module nixie_seg_decode
    import nixie_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = ~SEG_TABLE[hex];

endmodule

// File: rtl/nixie_scan_ctrl.sv
// Multiplexed 8-digit display scanner with double-buffered frame data.
// Latency: sel/seg/frame_done registered, one cycle behind scan state.
// Backpressure: wr_ready low while pending buffer holds an unapplied frame.
// Ports: clk, rst_n (async active-low), en (scan enable),
//        wr_valid/wr_ready/wr_data/wr_dp/wr_mask (frame write handshake),
//        sel/seg (active-low digit select and segments), frame_done (pulse).
module nixie_scan_ctrl
    import nixie_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [31:0]           wr_data,
    input  logic [NUM_DIGITS-1:0] wr_dp,
    input  logic [NUM_DIGITS-1:0] wr_mask,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    if (SCAN_DIV < BLANK_CYC + 1) begin : g_bad_params
        $error("nixie_scan_ctrl: SCAN_DIV must be at least BLANK_CYC+1");
    end

    localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYC);

    state_t                  state_q, state_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [2:0]              idx_q, idx_d;

    logic [31:0]             act_data, pend_data;
    logic [NUM_DIGITS-1:0]   act_dp, act_mask, pend_dp, pend_mask;
    logic                    pend_full;

    logic                    slot_end, frame_end, wr_fire, load_act;
    logic [6:0]              seg7_n;

    assign slot_end  = (state_q != ST_IDLE) && (presc_q == PRESC_MAX);
    assign frame_end = en && slot_end && (idx_q == 3'd7);
    assign wr_ready  = !pend_full;
    assign wr_fire   = wr_valid && wr_ready;
    // Pending frame applies immediately when dark, else only at a frame boundary
    // so a frame is never shown half-old, half-new.
    assign load_act  = pend_full && ((state_q == ST_IDLE) || frame_end);

    // Slot phase is a pure function of the prescaler: the first BLANK_CYC
    // counts are blank, the rest show the digit.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (!en || state_q == ST_IDLE) begin
            presc_d = '0;
            idx_d   = '0;
        end else if (slot_end) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
        end
        if (!en) begin
            state_d = ST_IDLE;
        end else if (presc_d < BLANK_LIM) begin
            state_d = ST_BLANK;
        end else begin
            state_d = ST_SHOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data  <= '0;
            act_dp    <= '0;
            act_mask  <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            pend_mask <= '0;
            pend_full <= 1'b0;
        end else if (load_act) begin
            act_data  <= pend_data;
            act_dp    <= pend_dp;
            act_mask  <= pend_mask;
            pend_full <= 1'b0;
        end else if (wr_fire) begin
            pend_data <= wr_data;
            pend_dp   <= wr_dp;
            pend_mask <= wr_mask;
            pend_full <= 1'b1;
        end
    end

    nixie_seg_decode u_dec (
        .hex   (act_data[{idx_q, 2'b00} +: 4]),
        .seg_n (seg7_n)
    );

    // Gating on en as well as state makes the display go dark on the very
    // next edge after en falls, rather than one cycle later via IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= '1;
            seg        <= '1;
            frame_done <= 1'b0;
        end else begin
            if (en && state_q == ST_SHOW && act_mask[idx_q]) begin
                sel <= ~(8'd1 << idx_q);
                seg <= {~act_dp[idx_q], seg7_n};
            end else begin
                sel <= '1;
                seg <= '1;
            end
            frame_done <= frame_end;
        end
    end

endmodule

// File: doc/nixie_scan_ctrl.md
NIXIE_SCAN_CTRL -- requirements
Module: nixie_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot.
REQ-002 SHALL have parameter BLANK_CYC, default 500, leading cycles of each slot with all digits off (anti-ghosting).
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port en  input  1  scan enable; low = display dark.
REQ-006 SHALL have port wr_valid  input  1  new frame data offered.
REQ-007 SHALL have port wr_ready  output  1  pending buffer free.
REQ-008 SHALL have port wr_data  input  32  hex value per digit, nibble i -> digit i.
REQ-009 SHALL have port wr_dp  input  8  decimal point per digit, 1 = lit.
REQ-010 SHALL have port wr_mask  input  8  digit enable per digit, 1 = shown.
REQ-011 SHALL have port sel  output  8  digit select, active-low, bit i = digit i.
REQ-012 SHALL have port seg  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at end of digit 7 slot.

Function
REQ-014 SHALL hold data, dp and mask in an active register set and a pending set.
REQ-015 SHALL capture wr_data/wr_dp/wr_mask into pending on the cycle wr_valid && wr_ready, then set pending-full.
REQ-016 SHALL drive wr_ready = !pending-full; wr_valid while not ready is ignored, never dropped silently once accepted.
REQ-017 SHALL have states IDLE, BLANK, SHOW.
REQ-018 IDLE (en=0): prescaler=0, digit index=0; a full pending set moves to active on the next cycle and clears pending-full.
REQ-019 IDLE -> BLANK when en=1; any state -> IDLE the cycle after en=0.
REQ-020 SHALL count prescaler 0..SCAN_DIV-1 per slot; BLANK for counts 0..BLANK_CYC-1, SHOW for the rest; BLANK_CYC=0 skips BLANK.
REQ-021 At prescaler wrap SHALL advance digit index modulo 8 (7 -> 0).
REQ-022 On the 7 -> 0 wrap SHALL pulse frame_done for one cycle and, if pending-full, copy pending to active and clear pending-full on that same edge.
REQ-023 Write accepted on the frame-boundary cycle while pending empty: SHALL go to pending and apply at the following boundary.
REQ-024 In SHOW with mask[idx]=1: sel = ~(1<<idx), seg = {~dp[idx], decode(data nibble idx)}.
REQ-025 In BLANK, IDLE, or SHOW with mask[idx]=0: sel = 8'hFF, seg = 8'hFF; slot timing unchanged by mask.
REQ-026 Decode SHALL cover 0-F (0=0x3F, 1=0x06, ..., F=0x71 active-high before inversion).
REQ-027 sel, seg, frame_done SHALL be registered; one-cycle latency from state/index to outputs.
REQ-028 At most one sel bit SHALL be low in any cycle.

Reset
REQ-029 rst_n low SHALL immediately force sel=8'hFF, seg=8'hFF, frame_done=0, wr_ready=1, state IDLE, prescaler 0, index 0, active and pending data/dp/mask 0, pending-full 0.
REQ-030 Reset mid-frame SHALL discard pending data; first slot after release starts at digit 0 with BLANK.

Structure
REQ-031 Shared package nixie_pkg SHALL hold NUM_DIGITS=8, the state enum type, and the 16-entry segment table constant.
REQ-032 Hex-to-segment decode SHALL be sub-module nixie_seg_decode (4-bit in, 7-bit active-low out, combinational).
REQ-033 Elaboration SHALL fail if SCAN_DIV < BLANK_CYC+1.

Verification (bench uses SCAN_DIV=4, BLANK_CYC=1)
REQ-034 Reset, write 0x76543210/dp 0x00/mask 0xFF, en=1 -> per digit 1 cycle sel=FF then 3 cycles sel=FE,FD,...,7F; digit0 seg=0xC0, digit1 seg=0xF9.
REQ-035 Write 0x00000008 mid-frame at digit 3 -> digits 3-7 keep old values; frame_done pulses; next digit0 shows seg=0x80.
REQ-036 Two back-to-back writes -> second sees wr_ready=0 until frame_done cycle, then accepted and shown one frame later.
REQ-037 mask=0x0F -> digits 4-7 slots sel=FF, seg=FF, still 4 cycles each; frame period 32 cycles.
REQ-038 en=0 during digit 3 SHOW -> next cycle outputs FF; re-enable restarts at digit 0 BLANK.
REQ-039 rst_n low mid-SHOW, asynchronous to clk -> sel=FF, seg=FF without waiting for a clock edge; wr_ready=1.
